// File: rtl/fm_dsp_pkg.sv
// fm_dsp_pkg: shared definitions for the FM audio filter blocks.
//   FRAC_BITS   - fractional bits of the Q10 sample/coefficient format
//   DATA_WIDTH  - sample, coefficient and accumulator width
//   iir_state_t - sequencing states of the time-multiplexed IIR filters
//   mul_q10     - signed Q10 multiply: full product, floor shift, truncate
package fm_dsp_pkg;

    localparam int FRAC_BITS  = 10;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } iir_state_t;

    // The arithmetic shift floors toward minus infinity (no rounding), and
    // the size cast keeps only the low DATA_WIDTH bits, so overflow wraps.
    function automatic logic signed [DATA_WIDTH-1:0] mul_q10(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
               $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        return DATA_WIDTH'(prod >>> FRAC_BITS);
    endfunction

endpackage

// File: rtl/q10_mac.sv
// q10_mac: combinational single-tap multiply-accumulate for the Q10 IIR
// filters (shared by pre-emphasis and de-emphasis).
//   acc      - running accumulator
//   x, bx    - feed-forward history sample and its coefficient
//   y, ay    - feedback history sample and its coefficient
//   en_y     - include the feedback product (low for tap 0)
//   acc_next - acc + x*bx (+ y*ay), wrapping, no saturation
module q10_mac
    import fm_dsp_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] acc,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] bx,
    input  logic signed [DATA_WIDTH-1:0] y,
    input  logic signed [DATA_WIDTH-1:0] ay,
    input  logic                         en_y,
    output logic signed [DATA_WIDTH-1:0] acc_next
);

    logic signed [DATA_WIDTH-1:0] ff_term;
    logic signed [DATA_WIDTH-1:0] fb_term;

    always_comb begin
        ff_term  = mul_q10(x, bx);
        fb_term  = '0;
        if (en_y) begin
            fb_term = mul_q10(y, ay);
        end
        acc_next = acc + ff_term + fb_term;
    end

endmodule

// File: rtl/iir_preemph.sv
// iir_preemph: transmit-side FM pre-emphasis, a time-multiplexed Q10 IIR
// sitting between an upstream FWFT FIFO and a downstream FIFO. One tap is
// evaluated per clock through a single shared q10_mac.
//   clock, reset_n       - clock and async active-low reset
//   in_dout, in_empty    - upstream FIFO data / empty flag
//   in_rd_en             - upstream pop strobe
//   out_din, out_wr_en   - downstream data (0 when not writing) / push strobe
//   out_full             - downstream FIFO full
//
// state | meaning
// ------+-------------------------------------------------------------
// READ  | wait for a sample; pop it into x_hist[0], clear acc and tap
// MAC   | accumulate one tap per cycle; latch result after the last tap
// WRITE | push result when downstream has room, then feed it back
module iir_preemph #(
    parameter int                         TAP_NUMBER = 2,
    parameter int                         DATA_WIDTH = 32,
    parameter logic signed [DATA_WIDTH-1:0] X_COEFF [0:TAP_NUMBER-1] = '{2926, -1902},
    parameter logic signed [DATA_WIDTH-1:0] Y_COEFF [0:TAP_NUMBER-1] = '{0, 0}
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en,
    input  logic                  out_full
);

    import fm_dsp_pkg::*;

    localparam int TAP_W = $clog2(TAP_NUMBER);

    iir_state_t                   state, state_nxt;
    logic signed [DATA_WIDTH-1:0] x_hist [0:TAP_NUMBER-1];
    // y_hist[0] is never loaded; it only keeps tap indexing uniform.
    logic signed [DATA_WIDTH-1:0] y_hist [0:TAP_NUMBER-1];
    logic signed [DATA_WIDTH-1:0] acc;
    logic signed [DATA_WIDTH-1:0] result;
    logic signed [DATA_WIDTH-1:0] mac_out;
    logic [TAP_W-1:0]             tap;
    logic                         last_tap;

    assign last_tap = (tap == TAP_W'(TAP_NUMBER - 1));

    q10_mac u_mac (
        .acc      (acc),
        .x        (x_hist[tap]),
        .bx       (X_COEFF[tap]),
        .y        (y_hist[tap]),
        .ay       (Y_COEFF[tap]),
        .en_y     (tap != '0),
        .acc_next (mac_out)
    );

    always_comb begin
        state_nxt = state;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;
        case (state)
            READ: begin
                // Reset forces READ; gating keeps the pop strobe low while
                // reset is held even if the upstream FIFO has data.
                if (!in_empty && reset_n) begin
                    in_rd_en  = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    out_din   = result;
                    state_nxt = READ;
                end
            end
            default: state_nxt = READ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= READ;
            acc    <= '0;
            result <= '0;
            tap    <= '0;
            for (int i = 0; i < TAP_NUMBER; i++) begin
                x_hist[i] <= '0;
                y_hist[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                READ: begin
                    if (in_rd_en) begin
                        x_hist[0] <= in_dout;
                        for (int i = TAP_NUMBER - 1; i > 0; i--) begin
                            x_hist[i] <= x_hist[i-1];
                        end
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= mac_out;
                    tap <= tap + 1'b1;
                    if (last_tap) begin
                        result <= mac_out;
                    end
                end
                WRITE: begin
                    if (out_wr_en) begin
                        y_hist[1] <= result;
                        for (int i = TAP_NUMBER - 1; i > 1; i--) begin
                            y_hist[i] <= y_hist[i-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_preemph.sv
// tb_iir_preemph: table-driven check of iir_preemph with default
// coefficients (dut_a) and with Y_COEFF = {0, 512} (dut_b) fed in parallel,
// plus hand-written backpressure and reset-mid-MAC sequences.
module tb_iir_preemph;

    localparam int N = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        out_full;
    logic        in_rd_en_a, in_rd_en_b;
    logic        out_wr_en_a, out_wr_en_b;
    logic [31:0] out_din_a, out_din_b;

    iir_preemph dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en_a),
        .out_din   (out_din_a),
        .out_wr_en (out_wr_en_a),
        .out_full  (out_full)
    );

    iir_preemph #(
        .Y_COEFF ('{32'sd0, 32'sd512})
    ) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en_b),
        .out_din   (out_din_b),
        .out_wr_en (out_wr_en_b),
        .out_full  (out_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int                 seq;
        logic signed [31:0] x;
        logic signed [31:0] y_def;
        logic signed [31:0] y_fb;
    } vec_t;

    vec_t               tab [12];
    logic signed [31:0] src [$];
    logic signed [31:0] cap_a [$];
    logic signed [31:0] cap_b [$];
    int                 wr_cyc [$];
    int                 pop_cyc [$];
    int                 cyc;
    int                 n_chk;
    int                 n_pass;
    bit                 hold_chk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive_in();
        in_empty = (src.size() == 0);
        in_dout  = (src.size() == 0) ? 32'd0 : src[0];
    endtask

    task automatic clear_logs();
        cap_a.delete();
        cap_b.delete();
        wr_cyc.delete();
        pop_cyc.delete();
    endtask

    // One clock: observe handshakes at negedge, act on them after posedge.
    task automatic step();
        bit pop_now;
        @(negedge clock);
        cyc++;
        if (hold_chk) begin
            check("hold_wr_en", 32'(out_wr_en_a), 0);
            check("hold_rd_en", 32'(in_rd_en_a), 0);
            check("hold_din", out_din_a, 0);
        end
        pop_now = in_rd_en_a;
        if (pop_now) pop_cyc.push_back(cyc);
        if (out_wr_en_a) begin
            cap_a.push_back(out_din_a);
            wr_cyc.push_back(cyc);
        end
        if (out_wr_en_b) cap_b.push_back(out_din_b);
        @(posedge clock);
        #1;
        if (pop_now && src.size() > 0) void'(src.pop_front());
        drive_in();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src.delete();
        drive_in();
        clear_logs();
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_seq(input int first, input int last);
        int n;
        int lim;
        logic signed [31:0] got;
        do_reset();
        n = last - first;
        for (int k = first; k < last; k++) src.push_back(tab[k].x);
        drive_in();
        lim = 0;
        while (cap_a.size() < n && lim < 100) begin
            step();
            lim++;
        end
        check($sformatf("seq%0d_count", tab[first].seq), cap_a.size(), n);
        for (int k = 0; k < n; k++) begin
            got = (k < cap_a.size()) ? cap_a[k] : 'x;
            check($sformatf("seq%0d_def[%0d]", tab[first].seq, k), got,
                  tab[first+k].y_def);
            got = (k < cap_b.size()) ? cap_b[k] : 'x;
            check($sformatf("seq%0d_fb[%0d]", tab[first].seq, k), got,
                  tab[first+k].y_fb);
        end
        if (pop_cyc.size() > 0 && wr_cyc.size() > 0)
            check($sformatf("seq%0d_latency", tab[first].seq),
                  wr_cyc[0] - pop_cyc[0], N + 1);
        if (wr_cyc.size() > 1)
            check($sformatf("seq%0d_period", tab[first].seq),
                  wr_cyc[1] - wr_cyc[0], N + 2);
    endtask

    initial begin
        int i;
        int j;
        int lim;
        int k0;
        int rel;

        n_chk    = 0;
        n_pass   = 0;
        cyc      = 0;
        hold_chk = 0;
        reset_n  = 1'b0;
        out_full = 1'b0;
        in_empty = 1'b1;
        in_dout  = '0;

        //         seq  x      y_def  y_fb
        tab[0]  = '{0,  1024,  2926,  2926};
        tab[1]  = '{0,  0,    -1902,  -439};
        tab[2]  = '{0,  0,     0,     -220};
        tab[3]  = '{0,  0,     0,     -110};
        tab[4]  = '{1,  1024,  2926,  2926};
        tab[5]  = '{1,  1024,  1024,  2487};
        tab[6]  = '{1,  1024,  1024,  2267};
        tab[7]  = '{1,  1024,  1024,  2157};
        tab[8]  = '{1,  1024,  1024,  2102};
        tab[9]  = '{1,  1024,  1024,  2075};
        tab[10] = '{2,  -1,    -3,    -3};
        tab[11] = '{2,  0,     1,     -1};

        // Reset state, with data pending upstream: no strobes, zero data.
        src.push_back(1024);
        drive_in();
        #2;
        check("rst_rd_en", 32'(in_rd_en_a), 0);
        check("rst_wr_en", 32'(out_wr_en_a), 0);
        check("rst_din", out_din_a, 0);

        i = 0;
        while (i < 12) begin
            j = i;
            while (j < 12 && tab[j].seq == tab[i].seq) j++;
            run_seq(i, j);
            i = j;
        end

        // Backpressure: out_full held high across WRITE with input pending.
        do_reset();
        out_full = 1'b1;
        src.push_back(1024);
        src.push_back(1024);
        drive_in();
        lim = 0;
        while (pop_cyc.size() == 0 && lim < 20) begin
            step();
            lim++;
        end
        check("bp_first_pop", pop_cyc.size(), 1);
        k0 = cyc;
        for (int s = 1; s <= 7; s++) begin
            hold_chk = (s >= N + 1);
            step();
        end
        hold_chk = 0;
        check("bp_no_write", cap_a.size(), 0);
        check("bp_no_pop", pop_cyc.size(), 1);
        out_full = 1'b0;
        rel = cyc + 1;
        lim = 0;
        while (cap_a.size() < 2 && lim < 30) begin
            step();
            lim++;
        end
        check("bp_count", cap_a.size(), 2);
        if (cap_a.size() == 2 && pop_cyc.size() >= 2) begin
            check("bp_val0", cap_a[0], 2926);
            check("bp_write_cyc", wr_cyc[0], rel);
            check("bp_next_pop", pop_cyc[1], wr_cyc[0] + 1);
            check("bp_val1", cap_a[1], 1024);
            check("bp_fb_val1", cap_b[1], 2487);
            check("bp_hold_len", wr_cyc[0] - (k0 + N + 1), 5);
        end

        // Reset mid-MAC discards the partial result and the history.
        do_reset();
        src.push_back(1024);
        drive_in();
        lim = 0;
        while (pop_cyc.size() == 0 && lim < 20) begin
            step();
            lim++;
        end
        check("mm_pop", pop_cyc.size(), 1);
        step();
        reset_n = 1'b0;
        src.push_back(1024);
        drive_in();
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check("mm_rst_rd_en", 32'(in_rd_en_a), 0);
            check("mm_rst_wr_en", 32'(out_wr_en_a), 0);
            check("mm_rst_din", out_din_a, 0);
            @(posedge clock);
            #1;
        end
        reset_n = 1'b1;
        clear_logs();
        lim = 0;
        while (cap_a.size() == 0 && lim < 20) begin
            step();
            lim++;
        end
        check("mm_count", cap_a.size(), 1);
        if (cap_a.size() > 0) check("mm_def", cap_a[0], 2926);
        if (cap_b.size() > 0) check("mm_fb", cap_b[0], 2926);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
